// File: rtl/demux_1_to_n_reg.sv
// demux_1_to_n_reg: registered 1-to-N valid/ready demultiplexer with a one-entry output buffer per channel
// Ports: clk, rst_n (async, active-low); in_data/in_sel/in_valid/in_ready input handshake;
// out_data (channel k at [k*DATA_W +: DATA_W]), out_valid/out_ready per-channel handshake;
// sel_err one-cycle pulse for a dropped out-of-range select; xfer_cnt words delivered (wraps).
// Optional: define DEMUX_BCAST_EN to add in_bcast, which loads in_data into every channel at once.
module demux_1_to_n_reg #(
  parameter int DATA_W = 8,
  parameter int N_OUT  = 4,
  parameter int SEL_W  = 2,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_W-1:0]       in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_valid,
`ifdef DEMUX_BCAST_EN
  input  logic                    in_bcast,
`endif
  output logic                    in_ready,
  output logic [N_OUT*DATA_W-1:0] out_data,
  output logic [N_OUT-1:0]        out_valid,
  input  logic [N_OUT-1:0]        out_ready,
  output logic                    sel_err,
  output logic [CNT_W-1:0]        xfer_cnt
);
  localparam logic [CNT_W-1:0] N_CNT = CNT_W'(N_OUT);
  logic [N_OUT-1:0] sel_hot, drain, free, load;
  logic bcast, sel_ok, accept;
`ifdef DEMUX_BCAST_EN
  assign bcast = in_bcast;
`else
  assign bcast = 1'b0;
`endif
  // sel_hot is all-zero for an out-of-range select, which doubles as the range check
  always_comb begin
    for (int k = 0; k < N_OUT; k++) sel_hot[k] = in_sel == SEL_W'(k);
  end
  assign drain    = out_valid & out_ready;
  // a channel can take a word if empty or draining this cycle (no bubble on back-to-back loads)
  assign free     = ~out_valid | drain;
  assign sel_ok   = |sel_hot;
  assign in_ready = bcast ? &free : (~sel_ok | (|(sel_hot & free)));
  assign accept   = in_valid & in_ready;
  assign load     = accept ? (bcast ? '1 : sel_hot) : '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= '0;
      out_data  <= '0;
      sel_err   <= 1'b0;
      xfer_cnt  <= '0;
    end else begin
      out_valid <= load | (out_valid & ~drain);
      sel_err   <= accept & ~bcast & ~sel_ok;
      if (accept & (bcast | sel_ok)) xfer_cnt <= xfer_cnt + (bcast ? N_CNT : CNT_W'(1));
      for (int k = 0; k < N_OUT; k++)
        if (load[k]) out_data[k*DATA_W +: DATA_W] <= in_data;
    end
  end
endmodule

// File: tb/tb_demux_1_to_n_reg.sv
// tb_demux_1_to_n_reg: directed self-checking bench for demux_1_to_n_reg
module tb_demux_1_to_n_reg;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic [7:0]  a_data = '0;
  logic [1:0]  a_sel = '0;
  logic        a_valid = 1'b0;
  logic        a_bcast = 1'b0;
  logic        a_in_ready;
  logic [31:0] a_out_data;
  logic [3:0]  a_out_valid;
  logic [3:0]  a_out_ready = '0;
  logic        a_sel_err;
  logic [3:0]  a_cnt;
  logic [7:0]  b_data = '0;
  logic [1:0]  b_sel = '0;
  logic        b_valid = 1'b0;
  logic        b_in_ready;
  logic [23:0] b_out_data;
  logic [2:0]  b_out_valid;
  logic [2:0]  b_out_ready = '0;
  logic        b_sel_err;
  logic [15:0] b_cnt;
  int checks = 0;
  int failures = 0;
  demux_1_to_n_reg #(.DATA_W(8), .N_OUT(4), .SEL_W(2), .CNT_W(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_data(a_data), .in_sel(a_sel), .in_valid(a_valid),
`ifdef DEMUX_BCAST_EN
    .in_bcast(a_bcast),
`endif
    .in_ready(a_in_ready), .out_data(a_out_data), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .sel_err(a_sel_err), .xfer_cnt(a_cnt)
  );
  demux_1_to_n_reg #(.DATA_W(8), .N_OUT(3), .SEL_W(2), .CNT_W(16)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .in_data(b_data), .in_sel(b_sel), .in_valid(b_valid),
`ifdef DEMUX_BCAST_EN
    .in_bcast(1'b0),
`endif
    .in_ready(b_in_ready), .out_data(b_out_data), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .sel_err(b_sel_err), .xfer_cnt(b_cnt)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [7:0] ch(input int k);
    return a_out_data[k*8 +: 8];
  endfunction
  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_valid", 32'(a_out_valid), 32'h0);
    check("rst_data", a_out_data, 32'h0);
    check("rst_cnt", 32'(a_cnt), 32'h0);
    check("rst_err", 32'(a_sel_err), 32'h0);
    for (int s = 0; s < 4; s++) begin
      a_sel = 2'(s);
      #1 check($sformatf("idle_ready_sel%0d", s), 32'(a_in_ready), 32'h1);
    end
    // invalid select on the 3-channel instance
    b_data = 8'h77; b_sel = 2'd3; b_valid = 1'b1;
    #1 check("bad_sel_ready", 32'(b_in_ready), 32'h1);
    @(posedge clk); #1;
    check("bad_sel_err", 32'(b_sel_err), 32'h1);
    check("bad_sel_valid", 32'(b_out_valid), 32'h0);
    check("bad_sel_cnt", 32'(b_cnt), 32'h0);
    b_sel = 2'd1; b_data = 8'h42;
    @(posedge clk); #1;
    b_valid = 1'b0;
    check("bad_sel_pulse", 32'(b_sel_err), 32'h0);
    check("b_good_valid", 32'(b_out_valid), 32'h2);
    check("b_good_data", 32'(b_out_data[15:8]), 32'h42);
    check("b_good_cnt", 32'(b_cnt), 32'h1);
    // unicast steering and same-cycle drain/load
    a_data = 8'hA5; a_sel = 2'd2; a_valid = 1'b1;
    #1 check("uni_ready0", 32'(a_in_ready), 32'h1);
    @(posedge clk); #1;
    check("uni_valid", 32'(a_out_valid), 32'h4);
    check("uni_data", 32'(ch(2)), 32'hA5);
    check("uni_cnt1", 32'(a_cnt), 32'h1);
    a_data = 8'h3C;
    #1 check("uni_full_ready", 32'(a_in_ready), 32'h0);
    a_out_ready = 4'b0100;
    #1 check("uni_drain_ready", 32'(a_in_ready), 32'h1);
    @(posedge clk); #1;
    check("uni_nobubble", 32'(a_out_valid), 32'h4);
    check("uni_data2", 32'(ch(2)), 32'h3C);
    check("uni_cnt2", 32'(a_cnt), 32'h2);
    a_valid = 1'b0;
    @(posedge clk); #1;
    check("uni_drained", 32'(a_out_valid), 32'h0);
    check("uni_hold", 32'(ch(2)), 32'h3C);
    check("uni_err", 32'(a_sel_err), 32'h0);
    a_out_ready = 4'b0000;
    // stall channel 0 full, stream into channel 1
    a_data = 8'hEE; a_sel = 2'd0; a_valid = 1'b1;
    @(posedge clk); #1;
    check("ch0_full", 32'(a_out_valid), 32'h1);
    a_out_ready = 4'b0010; a_sel = 2'd1;
    for (int i = 1; i <= 8; i++) begin
      a_data = 8'(i);
      #1 check($sformatf("strm_ready%0d", i), 32'(a_in_ready), 32'h1);
      @(posedge clk); #1;
      check($sformatf("strm_data%0d", i), 32'({a_out_valid[1], ch(1)}), 32'h100 | 32'(i));
    end
    a_valid = 1'b0;
    check("strm_ch0_data", 32'(ch(0)), 32'hEE);
    check("strm_ch0_valid", 32'(a_out_valid[0]), 32'h1);
    check("strm_cnt", 32'(a_cnt), 32'd11);
    // five more accepts give 16 in total: 4-bit counter wraps to 0
    a_out_ready = 4'b1111; a_sel = 2'd3; a_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      a_data = 8'(8'h90 + i);
      @(posedge clk); #1;
    end
    a_valid = 1'b0; a_out_ready = 4'b0000;
    check("wrap_cnt", 32'(a_cnt), 32'h0);
    check("wrap_data", 32'(ch(3)), 32'h94);
    a_data = 8'h11; a_sel = 2'd0; a_valid = 1'b1;
    @(posedge clk); #1;
    a_valid = 1'b0;
    check("pre_rst_valid", 32'(a_out_valid), 32'h9);
    check("pre_rst_cnt", 32'(a_cnt), 32'h1);
    // asynchronous reset between edges
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(a_out_valid), 32'h0);
    check("arst_cnt", 32'(a_cnt), 32'h0);
    check("arst_data", a_out_data, 32'h0);
    check("arst_b_valid", 32'(b_out_valid), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
`ifdef DEMUX_BCAST_EN
    a_data = 8'h5A; a_bcast = 1'b1; a_valid = 1'b1; a_sel = 2'd3;
    #1 check("bc_ready", 32'(a_in_ready), 32'h1);
    @(posedge clk); #1;
    a_valid = 1'b0;
    check("bc_valid", 32'(a_out_valid), 32'hF);
    check("bc_data", a_out_data, 32'h5A5A5A5A);
    check("bc_cnt", 32'(a_cnt), 32'h4);
    check("bc_err", 32'(a_sel_err), 32'h0);
    a_out_ready = 4'b1101;
    #1 check("bc_blocked", 32'(a_in_ready), 32'h0);
    a_out_ready = 4'b1111;
    #1 check("bc_alldrain", 32'(a_in_ready), 32'h1);
    a_bcast = 1'b0;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
